// File: rtl/alu_bitserial_seq.sv
// Bit-serial ALU: one 1-bit slice iterated LSB first, carry in a flop.
// Same op encoding and flags as the ripple ALU, start/busy/done handshake.
module alu_bitserial_seq #(
    parameter int WIDTH = 32,
    localparam int CW = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [2:0]       alu_op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic             overflow,
    output logic             carry_out
);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        FINISH
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic [WIDTH-1:0] res_sh;
    logic [2:0]       op_q;
    logic [CW-1:0]    cnt;
    logic             carry_ff;
    logic             v_q;
    logic             msb_q;
    logic             c_last;

    logic             bb;
    logic             sum;
    logic             cout;
    logic             bit_out;
    logic             is_arith;
    logic             is_slt;
    logic [WIDTH-1:0] res_final;

    always_comb begin
        bb       = b_sh[0] ^ op_q[2];
        sum      = a_sh[0] ^ bb ^ carry_ff;
        cout     = (a_sh[0] & bb) | (a_sh[0] & carry_ff) | (bb & carry_ff);
        is_slt   = (op_q == 3'b111);
        is_arith = (op_q == 3'b010) || (op_q == 3'b110) || is_slt;
        bit_out  = 1'b0;
        case (op_q)
            3'b000:         bit_out = a_sh[0] & bb;
            3'b001:         bit_out = a_sh[0] | bb;
            3'b010, 3'b110: bit_out = sum;
            default:        bit_out = 1'b0;
        endcase
        // SLT: sign of the difference, corrected by signed overflow
        if (is_slt)
            res_final = {{(WIDTH-1){1'b0}}, v_q ^ msb_q};
        else
            res_final = res_sh;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            a_sh      <= '0;
            b_sh      <= '0;
            res_sh    <= '0;
            op_q      <= '0;
            cnt       <= '0;
            carry_ff  <= 1'b0;
            v_q       <= 1'b0;
            msb_q     <= 1'b0;
            c_last    <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            result    <= '0;
            zero      <= 1'b1;
            overflow  <= 1'b0;
            carry_out <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        a_sh     <= a;
                        b_sh     <= b;
                        op_q     <= alu_op;
                        carry_ff <= alu_op[2];
                        cnt      <= '0;
                        busy     <= 1'b1;
                        state    <= RUN;
                    end
                end
                RUN: begin
                    res_sh   <= {bit_out, res_sh[WIDTH-1:1]};
                    a_sh     <= a_sh >> 1;
                    b_sh     <= b_sh >> 1;
                    carry_ff <= cout;
                    if (cnt == CW'(WIDTH - 1)) begin
                        v_q    <= carry_ff ^ cout;
                        msb_q  <= sum;
                        c_last <= cout;
                        state  <= FINISH;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                FINISH: begin
                    result    <= res_final;
                    zero      <= ~|res_final;
                    overflow  <= is_arith & v_q;
                    carry_out <= is_arith & c_last;
                    done      <= 1'b1;
                    busy      <= 1'b0;
                    state     <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
